// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry register file.
// Optional macro AES_KEY_EXP_SERIAL_SBOX_EN: single byte-serial s_box, 4 cycles per round key.

package aes_key_exp_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

module s_box (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    import aes_key_exp_pkg::*;

    assign o_data = sbox_affine(gf_inv(i_data));

endmodule

module aes_key_expansion #(
    parameter int KEY_WIDTH  = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [3:0]           rd_idx,
    output logic [KEY_WIDTH-1:0] rd_key,
    output logic                 keys_done,
    output logic                 busy
);
    import aes_key_exp_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_key_ready;
    logic                 r_busy;
    logic                 r_keys_done;
    logic                 w_key_ready_nxt;
    logic                 w_busy_nxt;
    logic                 w_keys_done_nxt;

    logic [KEY_WIDTH-1:0] r_rk [0:NUM_ROUNDS];
    logic [3:0]           r_cnt;
    logic [7:0]           r_rcon;

    logic                 w_accept;
    logic                 w_round_write;
    logic                 w_round_last;
    logic [KEY_WIDTH-1:0] w_prev_key;
    logic [KEY_WIDTH-1:0] w_new_key;
    logic [KEY_WIDTH-1:0] w_rd_key;
    logic [31:0]          w_rot;
    logic [31:0]          w_sub;
    logic [31:0]          w_t;
    logic [31:0]          w_n0;
    logic [31:0]          w_n1;
    logic [31:0]          w_n2;
    logic [31:0]          w_n3;

    assign w_accept     = key_valid && r_key_ready;
    assign w_round_last = w_round_write && (r_cnt == 4'(NUM_ROUNDS));

    // Select the previous round key rk[cnt-1]; zero outside the valid range.
    always_comb begin
        w_prev_key = {KEY_WIDTH{1'b0}};
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            w_prev_key = w_prev_key | ((r_cnt == 4'(i + 1)) ? r_rk[i] : {KEY_WIDTH{1'b0}});
        end
    end

    assign w_rot = {w_prev_key[23:0], w_prev_key[31:24]};

`ifdef AES_KEY_EXP_SERIAL_SBOX_EN
    logic [1:0]  r_sub;
    logic [23:0] r_sub_tmp;
    logic [7:0]  w_sbox_in;
    logic [7:0]  w_sbox_out;

    // Route one rotated byte per sub-step into the shared s_box.
    always_comb begin
        w_sbox_in = 8'h00;
        case (r_sub)
            2'd0:    w_sbox_in = w_rot[31:24];
            2'd1:    w_sbox_in = w_rot[23:16];
            2'd2:    w_sbox_in = w_rot[15:8];
            2'd3:    w_sbox_in = w_rot[7:0];
            default: w_sbox_in = 8'h00;
        endcase
    end

    s_box u_sbox (
        .i_data (w_sbox_in),
        .o_data (w_sbox_out)
    );

    // Last byte bypasses the temp register so sub-step 3 can write the round key.
    assign w_sub         = {r_sub_tmp, w_sbox_out};
    assign w_round_write = (r_state == ST_EXPAND) && (r_sub == 2'd3);

    // Sub-step counter and partial SubWord storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub     <= 2'd0;
            r_sub_tmp <= 24'h000000;
        end else if (w_accept) begin
            r_sub <= 2'd0;
        end else if (r_state == ST_EXPAND) begin
            case (r_sub)
                2'd0:    r_sub_tmp[23:16] <= w_sbox_out;
                2'd1:    r_sub_tmp[15:8]  <= w_sbox_out;
                2'd2:    r_sub_tmp[7:0]   <= w_sbox_out;
                default: r_sub_tmp        <= r_sub_tmp;
            endcase
            r_sub <= r_sub + 2'd1;
        end else begin
            r_sub <= r_sub;
        end
    end
`else
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        s_box u_sbox (
            .i_data (w_rot[31-8*g -: 8]),
            .o_data (w_sub[31-8*g -: 8])
        );
    end

    assign w_round_write = (r_state == ST_EXPAND);
`endif

    assign w_t       = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0      = w_prev_key[127:96] ^ w_t;
    assign w_n1      = w_n0 ^ w_prev_key[95:64];
    assign w_n2      = w_n1 ^ w_prev_key[63:32];
    assign w_n3      = w_n2 ^ w_prev_key[31:0];
    assign w_new_key = {w_n0, w_n1, w_n2, w_n3};

    // Round key register file, round counter and rcon.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk   <= '{default: {KEY_WIDTH{1'b0}}};
            r_cnt  <= 4'd0;
            r_rcon <= 8'h01;
        end else if (w_accept) begin
            r_rk[0] <= key_in;
            r_cnt   <= 4'd1;
            r_rcon  <= 8'h01;
        end else if (w_round_write) begin
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
                if (r_cnt == 4'(i)) begin
                    r_rk[i] <= w_new_key;
                end
            end
            r_cnt  <= r_cnt + 4'd1;
            r_rcon <= xtime(r_rcon);
        end else begin
            r_cnt  <= r_cnt;
            r_rcon <= r_rcon;
        end
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_keys_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key_ready <= w_key_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_keys_done <= w_keys_done_nxt;
        end
    end

    // Next-state logic; status outputs are decoded from the next state.
    always_comb begin
        w_state_nxt     = r_state;
        w_key_ready_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
        w_keys_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_accept ? ST_EXPAND : ST_IDLE;
            ST_EXPAND: w_state_nxt = w_round_last ? ST_DONE : ST_EXPAND;
            ST_DONE:   w_state_nxt = w_accept ? ST_EXPAND : ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        case (w_state_nxt)
            ST_EXPAND: begin
                w_key_ready_nxt = 1'b0;
                w_busy_nxt      = 1'b1;
            end
            ST_DONE:   w_keys_done_nxt = 1'b1;
            default:   w_keys_done_nxt = 1'b0;
        endcase
    end

    // Combinational read port; indices past the last round return zero.
    always_comb begin
        w_rd_key = {KEY_WIDTH{1'b0}};
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            w_rd_key = w_rd_key | ((rd_idx == 4'(i)) ? r_rk[i] : {KEY_WIDTH{1'b0}});
        end
    end

    assign rd_key    = w_rd_key;
    assign key_ready = r_key_ready;
    assign busy      = r_busy;
    assign keys_done = r_keys_done;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion: driver pushes expected round keys, monitor checks on keys_done.
`timescale 1ns/1ps
module tb_aes_key_expansion;

`ifdef AES_KEY_EXP_SERIAL_SBOX_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 1;
`endif

    typedef logic [10:0][127:0] rks_t;
    typedef struct packed {
        logic [31:0] done_cyc;
        rks_t        rk;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         keys_done;
    logic         busy;

    logic [7:0]   sbox_t [0:255];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    exp_t         sb_q[$];
    bit           chk_req = 1'b0;

    aes_key_expansion dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .keys_done (keys_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return gmul_ret(p);
    endfunction

    function automatic logic [7:0] gmul_ret(input logic [7:0] v);
        return v;
    endfunction

    // S-box table by brute-force inverse search plus the FIPS-197 affine map.
    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
            end
            sbox_t[x] = s;
        end
    endtask

    // Word-oriented FIPS-197 key expansion over w[0..43].
    function automatic rks_t ref_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [7:0]  rc = 8'h01;
        rks_t        r;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    task automatic scan(input rks_t exp_rk, input string tag);
        for (int i = 0; i < 16; i++) begin
            logic [127:0] e;
            rd_idx = 4'(i);
            #1;
            e = (i <= 10) ? exp_rk[i] : 128'h0;
            chk($sformatf("%s_rk%0d", tag, i), rd_key, e);
        end
    endtask

    // Monitor: pops an expectation on each keys_done rise or explicit reset-check request.
    initial begin
        logic prev_done = 1'b0;
        exp_t it;
        rd_idx = 4'd0;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                it = sb_q.pop_front();
                scan(it.rk, "reset");
                chk_req = 1'b0;
            end else if (keys_done === 1'b1 && !prev_done) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_keys_done: got=1 expected no completion at cycle %0d", cyc);
                end else begin
                    it = sb_q.pop_front();
                    chk("done_cycle", 128'(cyc), 128'(it.done_cyc));
                    scan(it.rk, "key");
                end
            end
            prev_done = (keys_done === 1'b1);
        end
    end

    task automatic send(input logic [127:0] key, input rks_t exp_rk, input bit push,
                        input bit hold, output int hs);
        int t;
        exp_t it;
        key_in    = key;
        key_valid = 1'b1;
        for (t = 0; t < 50 * STEP + 20 && key_ready !== 1'b1; t++) @(negedge clk);
        n_tests++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_timeout: got key_ready=%b expected 1", key_ready);
        end
        hs = cyc + 1;
        if (push) begin
            it.done_cyc = 32'(hs + 10 * STEP);
            it.rk       = exp_rk;
            sb_q.push_back(it);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) key_valid = 1'b0;
        chk("busy_after_hs", busy, 1'b1);
        chk("ready_after_hs", key_ready, 1'b0);
        chk("done_after_hs", keys_done, 1'b0);
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 60 * STEP + 40 && (sb_q.size() != 0 || chk_req); t++) @(negedge clk);
        chk("drain_pending", 128'(sb_q.size() + int'(chk_req)), 128'h0);
    endtask

    task automatic reset_and_check(input string tag);
        exp_t it;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, key_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, keys_done, 1'b0);
        it.done_cyc = 32'h0;
        it.rk       = '0;
        sb_q.push_back(it);
        chk_req = 1'b1;
        rst = 1'b0;
        drain();
    endtask

    // Driver: directed vectors first, then randomized keys.
    initial begin
        logic [127:0] ka;
        logic [127:0] kb;
        rks_t         ea;
        rks_t         e;
        int           hs;

        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = 128'h0;
        build_sbox();
        repeat (2) @(posedge clk);
        reset_and_check("init");

        ka    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ea    = ref_expand(ka);
        ea[0] = ka;
        ea[1] = 128'ha0fafe1788542cb123a339392a6c7605;
        ea[2] = 128'hf2c295f27a96b9435935807a7359f67f;
        ea[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        send(ka, ea, 1'b1, 1'b0, hs);
        drain();
        chk("done_ready", key_ready, 1'b1);
        chk("done_busy", busy, 1'b0);

        e     = ref_expand(128'h0);
        e[1]  = 128'h62636363626363636263636362636363;
        e[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        send(128'h0, e, 1'b1, 1'b0, hs);
        drain();

        kb = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(ka, ea, 1'b1, 1'b1, hs);
        key_in = kb;
        send(kb, ref_expand(kb), 1'b1, 1'b0, hs);
        drain();

        send(ka, ea, 1'b0, 1'b0, hs);
        while (cyc < hs + 4 * STEP - 1) @(negedge clk);
        reset_and_check("midrst");
        send(ka, ea, 1'b1, 1'b0, hs);
        drain();

        for (int n = 0; n < 6; n++) begin
            kb = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(kb, ref_expand(kb), 1'b1, 1'b0, hs);
            if (n % 2 == 1) drain();
        end
        drain();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
